// File: rtl/jtoutrun_ram_resp_if.sv
// ---------------------------------------------------------------------------
// jtoutrun_ram_resp_if
//
// Bundles the two buses the RAM responder sits between:
//   * CPU side   : ram_cs / vram_cs select, word address, byte write strobes,
//                  write data in, read data + ok strobe out.
//   * SDRAM side : one slot request (addr, cs, we, dsn, din) out and the
//                  arbiter's ack / rdy pulses plus read data back.
//
// Modports:
//   slave  - the responder's view (takes CPU requests, drives the SDRAM slot)
//   master - the environment's view (CPU + SDRAM arbiter, e.g. a testbench)
//
// Parameters:
//   AW  - CPU word-address width (addr[AW:1])
//   SDW - SDRAM word-address width
// ---------------------------------------------------------------------------
interface jtoutrun_ram_resp_if #(
    parameter int AW  = 15,
    parameter int SDW = 22
) ();
    // CPU side
    logic            ram_cs;
    logic            vram_cs;
    logic [AW:1]     addr;
    logic            UDSWn;
    logic            LDSWn;
    logic [15:0]     cpu_dout;
    logic [15:0]     ram_data;
    logic            ram_ok;

    // SDRAM slot side
    logic [SDW-1:0]  sdram_addr;
    logic            sdram_cs;
    logic            sdram_we;
    logic [1:0]      sdram_dsn;
    logic [15:0]     sdram_din;
    logic [15:0]     sdram_dout;
    logic            sdram_ack;
    logic            sdram_rdy;

    modport slave (
        input  ram_cs, vram_cs, addr, UDSWn, LDSWn, cpu_dout,
        output ram_data, ram_ok,
        output sdram_addr, sdram_cs, sdram_we, sdram_dsn, sdram_din,
        input  sdram_dout, sdram_ack, sdram_rdy
    );

    modport master (
        output ram_cs, vram_cs, addr, UDSWn, LDSWn, cpu_dout,
        input  ram_data, ram_ok,
        input  sdram_addr, sdram_cs, sdram_we, sdram_dsn, sdram_din,
        output sdram_dout, sdram_ack, sdram_rdy
    );
endinterface

// File: rtl/jtoutrun_ram_resp.sv
// ---------------------------------------------------------------------------
// jtoutrun_ram_resp
//
// Responder for the OutRun main CPU work-RAM / VRAM accesses. Each CPU access
// becomes one SDRAM slot transaction; the returned word is handed back to the
// CPU together with a level ok strobe that stays up until the CPU releases
// its chip select. A one-word read cache lets repeated reads of the same word
// finish in a single cycle without touching the SDRAM.
//
// Ports:
//   clk   - system clock
//   rstn  - synchronous reset, active low
//   bus   - jtoutrun_ram_resp_if.slave
//             CPU   : ram_cs, vram_cs, addr, UDSWn, LDSWn, cpu_dout (in)
//                     ram_data, ram_ok (out)
//             SDRAM : sdram_addr, sdram_cs, sdram_we, sdram_dsn,
//                     sdram_din (out); sdram_dout, sdram_ack,
//                     sdram_rdy (in)
//
// Parameters:
//   AW       - CPU word-address width (addr[AW:1])
//   SDW      - SDRAM word-address width
//   BASE     - SDRAM word offset of the RAM region
//   CACHE_EN - 1 enables the one-word read cache, 0 sends every read to SDRAM
// ---------------------------------------------------------------------------
module jtoutrun_ram_resp #(
    parameter int          AW       = 15,
    parameter int          SDW      = 22,
    parameter int unsigned BASE     = 32'h0010_0000,
    parameter int          CACHE_EN = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    jtoutrun_ram_resp_if.slave   bus
);

    // Access key = {vram_cs, addr}: one bit wider than the CPU address so
    // that work RAM and VRAM occupy separate halves of the SDRAM region.
    localparam int KW       = AW + 1;
    localparam bit CACHE_ON = (CACHE_EN != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q,   state_d;

    // Latched request, held stable towards the SDRAM arbiter
    logic [KW-1:0]   key_q,     key_d;
    logic            we_q,      we_d;
    logic [1:0]      dsn_q,     dsn_d;
    logic [15:0]     din_q,     din_d;
    logic [SDW-1:0]  sdaddr_q,  sdaddr_d;
    logic            sdcs_q,    sdcs_d;

    // CPU response
    logic            ok_q,      ok_d;
    logic [15:0]     rdata_q,   rdata_d;

    // One-word read cache
    logic [15:0]     cache_q,   cache_d;
    logic [KW-1:0]   ckey_q,    ckey_d;
    logic            cvld_q,    cvld_d;

    // served: the current CPU access already got its ok; blocks a second
    // start until the CPU drops cs.
    // abort : cs went low while the SDRAM transaction was in flight, so its
    // result must not be reported even if a new cs is already high.
    logic            served_q,  served_d;
    logic            abort_q,   abort_d;

    // ---------------------------------------------------------------------
    // Combinational decode of the CPU request
    // ---------------------------------------------------------------------
    logic            cs;
    logic [KW-1:0]   key_in;
    logic            wr_in;
    logic            hit;
    logic            complete;
    logic [15:0]     merge_word;

    assign cs     = bus.ram_cs | bus.vram_cs;
    assign key_in = {bus.vram_cs, bus.addr};
    assign wr_in  = ~(bus.UDSWn & bus.LDSWn);
    assign hit    = CACHE_ON && cvld_q && (ckey_q == key_in) && !wr_in;

    // Data phase finishes either together with the ack (both pulses in the
    // same cycle) or later, while waiting.
    assign complete = ((state_q == REQ)  && bus.sdram_ack && bus.sdram_rdy) ||
                      ((state_q == WAIT) && bus.sdram_rdy);

    // Byte-lane merge of a write into the cached word. dsn bit 1 is the
    // upper byte, bit 0 the lower byte; a low strobe takes the new data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_merge
            assign merge_word[gi*8 +: 8] = dsn_q[gi] ? cache_q[gi*8 +: 8]
                                                     : din_q[gi*8 +: 8];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        we_d     = we_q;
        dsn_d    = dsn_q;
        din_d    = din_q;
        sdaddr_d = sdaddr_q;
        sdcs_d   = sdcs_q;
        ok_d     = ok_q;
        rdata_d  = rdata_q;
        cache_d  = cache_q;
        ckey_d   = ckey_q;
        cvld_d   = cvld_q;
        served_d = served_q;
        abort_d  = abort_q;

        if (!cs) begin
            served_d = 1'b0;
        end

        // Remember a cs drop while the slot transaction is outstanding
        if (((state_q == REQ) || (state_q == WAIT)) && !cs) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs && !served_q) begin
                    if (hit) begin
                        rdata_d  = cache_q;
                        ok_d     = 1'b1;
                        served_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        key_d    = key_in;
                        we_d     = wr_in;
                        dsn_d    = wr_in ? {bus.UDSWn, bus.LDSWn} : 2'b00;
                        din_d    = bus.cpu_dout;
                        // Modulo-2^SDW offset into the RAM region
                        sdaddr_d = SDW'(BASE) + SDW'(key_in);
                        sdcs_d   = 1'b1;
                        abort_d  = 1'b0;
                        state_d  = REQ;
                    end
                end
            end

            REQ: begin
                if (bus.sdram_ack) begin
                    sdcs_d  = 1'b0;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                // Completion handled below, shared with REQ
            end

            DONE: begin
                if (!cs) begin
                    ok_d    = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete) begin
            // Cache maintenance happens even for aborted accesses so the
            // cached word never goes stale relative to SDRAM.
            if (!we_q) begin
                cache_d = bus.sdram_dout;
                ckey_d  = key_q;
                cvld_d  = CACHE_ON;
            end else if (cvld_q && (ckey_q == key_q)) begin
                cache_d = merge_word;
            end

            if (cs && !abort_q) begin
                if (!we_q) begin
                    rdata_d = bus.sdram_dout;
                end
                ok_d     = 1'b1;
                served_d = 1'b1;
                state_d  = DONE;
            end else begin
                state_d  = IDLE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            key_q    <= '0;
            we_q     <= 1'b0;
            dsn_q    <= 2'b11;
            din_q    <= '0;
            sdaddr_q <= '0;
            sdcs_q   <= 1'b0;
            ok_q     <= 1'b0;
            rdata_q  <= '0;
            cache_q  <= '0;
            ckey_q   <= '0;
            cvld_q   <= 1'b0;
            served_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            we_q     <= we_d;
            dsn_q    <= dsn_d;
            din_q    <= din_d;
            sdaddr_q <= sdaddr_d;
            sdcs_q   <= sdcs_d;
            ok_q     <= ok_d;
            rdata_q  <= rdata_d;
            cache_q  <= cache_d;
            ckey_q   <= ckey_d;
            cvld_q   <= cvld_d;
            served_q <= served_d;
            abort_q  <= abort_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.ram_data   = rdata_q;
    assign bus.ram_ok     = ok_q;
    assign bus.sdram_addr = sdaddr_q;
    assign bus.sdram_cs   = sdcs_q;
    assign bus.sdram_we   = we_q;
    assign bus.sdram_dsn  = dsn_q;
    assign bus.sdram_din  = din_q;

endmodule

// File: tb/tb_jtoutrun_ram_resp.sv
// ---------------------------------------------------------------------------
// tb_jtoutrun_ram_resp
//
// Directed bench for jtoutrun_ram_resp. Stimulus pushes the expected SDRAM
// request (plus the word the SDRAM model returns for it) and the expected
// CPU read data into queues; an SDRAM model pops and checks requests, and a
// CPU-side monitor pops and checks data on every rising ram_ok.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtoutrun_ram_resp;

    localparam int AW  = 15;
    localparam int SDW = 22;

    typedef struct {
        logic [SDW-1:0] a;
        bit             we;
        logic [1:0]     dsn;
        logic [15:0]    din;
        logic [15:0]    rd;
    } req_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    jtoutrun_ram_resp_if #(.AW(AW), .SDW(SDW)) bus ();

    jtoutrun_ram_resp #(
        .AW       (AW),
        .SDW      (SDW),
        .BASE     (32'h0010_0000),
        .CACHE_EN (1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          sd_req_n = 0;
    int          ack_dly = 2;
    int          rdy_dly = 5;
    req_t        req_q[$];
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // SDRAM arbiter model: checks each request, then pulses ack / rdy
    // ------------------------------------------------------------------
    initial begin
        bus.sdram_ack  = 1'b0;
        bus.sdram_rdy  = 1'b0;
        bus.sdram_dout = 16'h0000;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && bus.sdram_cs === 1'b1) begin
                req_t e;
                int   ad, rd;
                bit   overlap;
                ad = ack_dly;
                rd = rdy_dly;
                overlap = 1'b0;
                sd_req_n++;
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sd_unexpected: got request addr %h, want none", bus.sdram_addr);
                    e = '{a: '0, we: 1'b0, dsn: 2'b00, din: 16'h0, rd: 16'h0};
                end else begin
                    e = req_q.pop_front();
                    chk("sd_addr", 32'(bus.sdram_addr), 32'(e.a));
                    chk("sd_we",   32'(bus.sdram_we),   32'(e.we));
                    chk("sd_dsn",  32'(bus.sdram_dsn),  32'(e.dsn));
                    if (e.we) chk("sd_din", 32'(bus.sdram_din), 32'(e.din));
                end
                $display("sdram req addr=%h we=%0d dsn=%b din=%h ret=%h ack+%0d rdy+%0d",
                         bus.sdram_addr, bus.sdram_we, bus.sdram_dsn, bus.sdram_din, e.rd, ad, rd);
                for (int t = 1; t <= rd; t++) begin
                    if (t > ad && bus.sdram_cs === 1'b1) overlap = 1'b1;
                    bus.sdram_ack  = (t == ad);
                    bus.sdram_rdy  = (t == rd);
                    bus.sdram_dout = (t == rd) ? e.rd : 16'h0000;
                    @(negedge clk);
                end
                bus.sdram_ack  = 1'b0;
                bus.sdram_rdy  = 1'b0;
                bus.sdram_dout = 16'h0000;
                chk("sd_cs_after_ack", 32'(overlap), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU-side monitor: every rising ram_ok consumes one expected word
    // ------------------------------------------------------------------
    initial begin
        logic ok_prev;
        ok_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ram_ok === 1'b1 && !ok_prev) begin
                chk("ok_with_cs", 32'(bus.ram_cs | bus.vram_cs), 32'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ok_unexpected: got ram_ok with data %h, want no ok", bus.ram_data);
                end else begin
                    logic [15:0] w;
                    w = exp_q.pop_front();
                    chk("ram_data", 32'(bus.ram_data), 32'(w));
                    $display("cpu ok data=%h expected=%h", bus.ram_data, w);
                end
            end
            ok_prev = (bus.ram_ok === 1'b1);
        end
    end

    // One CPU access; caller is at a negedge. exp_lat counts negedges from
    // the driving negedge to the first one that sees ram_ok.
    task automatic access(input bit v, input logic [AW:1] a, input bit un, input bit ln,
                          input logic [15:0] wd, input logic [SDW-1:0] exp_sa,
                          input logic [15:0] sd_ret, input logic [15:0] exp_rd,
                          input bit is_hit, input int exp_lat);
        int lat;
        int req_before;
        bit got;
        req_before = sd_req_n;
        if (!is_hit) begin
            req_q.push_back('{a: exp_sa, we: !(un & ln), dsn: (un & ln) ? 2'b00 : {un, ln},
                              din: wd, rd: sd_ret});
        end
        exp_q.push_back(exp_rd);
        bus.vram_cs  = v;
        bus.ram_cs   = !v;
        bus.addr     = a;
        bus.UDSWn    = un;
        bus.LDSWn    = ln;
        bus.cpu_dout = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (bus.ram_ok === 1'b1) got = 1'b1;
        end
        chk("ok_seen", 32'(got), 32'd1);
        chk("ok_latency", 32'(lat), 32'(exp_lat));
        if (is_hit) chk("hit_no_sdram", 32'(sd_req_n), 32'(req_before));
        bus.ram_cs  = 1'b0;
        bus.vram_cs = 1'b0;
        @(negedge clk);
        chk("ok_drop", 32'(bus.ram_ok), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit got;

        // 1. Reset held with cs high
        bus.ram_cs   = 1'b1;
        bus.vram_cs  = 1'b0;
        bus.addr     = 15'h0010;
        bus.UDSWn    = 1'b1;
        bus.LDSWn    = 1'b1;
        bus.cpu_dout = 16'h0000;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ram_ok",    32'(bus.ram_ok),    32'd0);
        chk("rst_sdram_cs",  32'(bus.sdram_cs),  32'd0);
        chk("rst_sdram_dsn", 32'(bus.sdram_dsn), 32'd3);
        chk("rst_ram_data",  32'(bus.ram_data),  32'd0);
        chk("rst_sdram_we",  32'(bus.sdram_we),  32'd0);
        rstn = 1'b1;
        access(1'b0, 15'h0010, 1'b1, 1'b1, 16'h0000, 22'h100010, 16'h1111, 16'h1111, 1'b0, 6);

        // 2. VRAM read miss, then hit on the same key
        access(1'b1, 15'h1234, 1'b1, 1'b1, 16'h0000, 22'h109234, 16'hBEEF, 16'hBEEF, 1'b0, 6);
        access(1'b1, 15'h1234, 1'b1, 1'b1, 16'h0000, 22'h000000, 16'h0000, 16'hBEEF, 1'b1, 1);

        // 3. Lower-byte write merges into the cached word; data bus holds
        access(1'b1, 15'h1234, 1'b1, 1'b0, 16'h0055, 22'h109234, 16'h0000, 16'hBEEF, 1'b0, 6);
        access(1'b1, 15'h1234, 1'b1, 1'b1, 16'h0000, 22'h000000, 16'h0000, 16'hBE55, 1'b1, 1);

        // 4. Same address in work RAM is a different key
        access(1'b0, 15'h1234, 1'b1, 1'b1, 16'h0000, 22'h101234, 16'h2222, 16'h2222, 1'b0, 6);

        // 5. Abort during WAIT, new read held high meanwhile
        rdy_dly = 8;
        req_q.push_back('{a: 22'h100040, we: 1'b0, dsn: 2'b00, din: 16'h0, rd: 16'h4444});
        bus.ram_cs = 1'b1;
        bus.addr   = 15'h0040;
        repeat (4) @(negedge clk);
        chk("abort_in_wait", 32'(bus.sdram_cs), 32'd0);
        bus.ram_cs = 1'b0;
        @(negedge clk);
        rdy_dly = 5;
        req_q.push_back('{a: 22'h100050, we: 1'b0, dsn: 2'b00, din: 16'h0, rd: 16'h3333});
        exp_q.push_back(16'h3333);
        bus.ram_cs = 1'b1;
        bus.addr   = 15'h0050;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (bus.ram_ok === 1'b1) got = 1'b1;
        end
        chk("abort_next_ok", 32'(got), 32'd1);
        chk("abort_next_latency", 32'(lat), 32'd10);
        bus.ram_cs = 1'b0;
        @(negedge clk);
        chk("abort_ok_drop", 32'(bus.ram_ok), 32'd0);

        // 6. Write with ack and rdy together, then hit on the merged word
        ack_dly = 3;
        rdy_dly = 3;
        access(1'b0, 15'h0050, 1'b0, 1'b0, 16'hA5A5, 22'h100050, 16'h0000, 16'h3333, 1'b0, 4);
        ack_dly = 2;
        rdy_dly = 5;
        access(1'b0, 15'h0050, 1'b1, 1'b1, 16'h0000, 22'h000000, 16'h0000, 16'hA5A5, 1'b1, 1);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
